// File: rtl/bubsys_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bubsys_pkg
//  Description : Shared types and helpers for the BubSys ioctl upload path:
//                FSM state encoding, parameter defaults, byte selection.
//  Revision    : 1.0  initial release
// ============================================================================
package bubsys_pkg;

   // Upload responder states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ABORT = 2'd2
   } upl_state_t;

   localparam logic [15:0] c_UPLOAD_INDEX_DEF = 16'd4;
   localparam logic [31:0] c_IMG_BYTES_DEF    = 32'd163840;

   // Big-endian (68000) byte lane: even byte address is the high byte
   function automatic logic [7:0] byte_sel(input logic [15:0] data, input logic lsb);
      return lsb ? data[7:0] : data[15:8];
   endfunction

endpackage
`default_nettype wire

// File: rtl/bubsys_ioctl_upload.sv
`default_nettype none
// ============================================================================
//  Module      : bubsys_ioctl_upload
//  Description : Byte-serial responder for the HPS ioctl upload channel.
//                Serves the bubble-memory save image one byte per ioctl_rd
//                from a 16-bit word buffer through a one-word cache, and
//                stalls the HPS with ioctl_wait while a word fetch is open.
//  Revision    : 1.0  initial release
// ============================================================================
module bubsys_ioctl_upload
   import bubsys_pkg::*;
#(
   parameter logic [15:0] UPLOAD_INDEX = c_UPLOAD_INDEX_DEF,
   parameter logic [31:0] IMG_BYTES    = c_IMG_BYTES_DEF,
   parameter int          MEM_AW       = 17
)(
   input  logic              i_EMU_CLK72M,
   input  logic              i_EMU_INITRST,

   input  logic              ioctl_upload,
   input  logic [15:0]       ioctl_index,
   input  logic              ioctl_rd,
   input  logic [26:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,

   output logic              o_MEM_LOCK,
   output logic [MEM_AW-1:0] o_MEM_ADDR,
   output logic              o_MEM_RD,
   input  logic [15:0]       i_MEM_DATA,
   input  logic              i_MEM_RDY
);

   logic              w_sel;
   logic              w_sel_rise;
   logic              w_in_range;
   logic              w_hit;
   logic [MEM_AW-1:0] w_word_addr;

   upl_state_t        r_state;
   logic [15:0]       r_cache_word;
   logic [MEM_AW-1:0] r_cache_tag;
   logic              r_cache_valid;
   logic              r_lsb;

   // o_MEM_LOCK is the registered session select, so it doubles as the
   // previous-cycle value for edge detection.
   assign w_sel       = ioctl_upload & (ioctl_index == UPLOAD_INDEX);
   assign w_sel_rise  = w_sel & ~o_MEM_LOCK;
   assign w_in_range  = ({5'd0, ioctl_addr} < IMG_BYTES);
   assign w_word_addr = ioctl_addr[MEM_AW:1];
   // A strobe on the very first cycle of a session must not hit stale data
   assign w_hit       = r_cache_valid & ~w_sel_rise & (r_cache_tag == w_word_addr);

   // Session tracking, cache maintenance and the strobe/fetch state machine
   always_ff @(posedge i_EMU_CLK72M or posedge i_EMU_INITRST) begin
      if (i_EMU_INITRST) begin
         r_state       <= IDLE;
         r_cache_word  <= 16'h0000;
         r_cache_tag   <= '0;
         r_cache_valid <= 1'b0;
         r_lsb         <= 1'b0;
         ioctl_din     <= 8'h00;
         ioctl_wait    <= 1'b0;
         o_MEM_LOCK    <= 1'b0;
         o_MEM_ADDR    <= '0;
         o_MEM_RD      <= 1'b0;
      end else begin
         o_MEM_LOCK <= w_sel;
         if (w_sel_rise) begin
            r_cache_valid <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (ioctl_rd && w_sel) begin
                  if (!w_in_range) begin
                     ioctl_din <= 8'hFF;
                  end else if (w_hit) begin
                     ioctl_din <= byte_sel(r_cache_word, ioctl_addr[0]);
                  end else begin
                     r_lsb      <= ioctl_addr[0];
                     o_MEM_ADDR <= w_word_addr;
                     o_MEM_RD   <= 1'b1;
                     ioctl_wait <= 1'b1;
                     r_state    <= FETCH;
                  end
               end
            end

            FETCH: begin
               if (!w_sel) begin
                  // Session ended: release the HPS now, but the memory request
                  // is already committed and must run to its acknowledge.
                  ioctl_wait <= 1'b0;
                  if (i_MEM_RDY) begin
                     o_MEM_RD <= 1'b0;
                     r_state  <= IDLE;
                  end else begin
                     r_state  <= ABORT;
                  end
               end else if (i_MEM_RDY) begin
                  o_MEM_RD      <= 1'b0;
                  r_cache_word  <= i_MEM_DATA;
                  r_cache_tag   <= o_MEM_ADDR;
                  r_cache_valid <= 1'b1;
                  ioctl_din     <= byte_sel(i_MEM_DATA, r_lsb);
                  ioctl_wait    <= 1'b0;
                  r_state       <= IDLE;
               end
            end

            ABORT: begin
               // Drain the orphaned request; its data belongs to no session
               if (i_MEM_RDY) begin
                  o_MEM_RD <= 1'b0;
                  r_state  <= IDLE;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bubsys_ioctl_upload.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bubsys_ioctl_upload
//  Description : Self-checking bench for bubsys_ioctl_upload: vector table,
//                hand-written abort/reset sequences and randomized reads
//                checked against an image-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bubsys_ioctl_upload;

   localparam int   c_IMG   = 163840;
   localparam int   c_WORDS = c_IMG / 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ioctl_upload = 1'b0;
   logic [15:0] ioctl_index = 16'd0;
   logic        ioctl_rd = 1'b0;
   logic [26:0] ioctl_addr = 27'd0;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic        o_MEM_LOCK;
   logic [16:0] o_MEM_ADDR;
   logic        o_MEM_RD;
   logic [15:0] i_MEM_DATA = 16'h0000;
   logic        i_MEM_RDY = 1'b0;

   logic [15:0] mem_img [0:c_WORDS-1];
   int          mem_delay = 1;
   bit          mem_auto = 1'b1;
   int          kick_req = 0;
   int          kick_ack = 0;
   int          mem_reads = 0;
   int          rd_cycles = 0;
   int          mem_cnt = 0;

   int          total = 0;
   int          bad = 0;

   bubsys_ioctl_upload dut (
      .i_EMU_CLK72M (clk),
      .i_EMU_INITRST(rst),
      .ioctl_upload (ioctl_upload),
      .ioctl_index  (ioctl_index),
      .ioctl_rd     (ioctl_rd),
      .ioctl_addr   (ioctl_addr),
      .ioctl_din    (ioctl_din),
      .ioctl_wait   (ioctl_wait),
      .o_MEM_LOCK   (o_MEM_LOCK),
      .o_MEM_ADDR   (o_MEM_ADDR),
      .o_MEM_RD     (o_MEM_RD),
      .i_MEM_DATA   (i_MEM_DATA),
      .i_MEM_RDY    (i_MEM_RDY)
   );

   always #5 clk = ~clk;

   // Buffer memory: acknowledges a held request after mem_delay cycles, or on demand
   always @(posedge clk) begin
      #1;
      if (o_MEM_RD) rd_cycles++;
      if (i_MEM_RDY) begin
         i_MEM_RDY = 1'b0;
      end else if (rst) begin
         mem_cnt = 0;
      end else if (o_MEM_RD) begin
         mem_cnt++;
         if ((mem_auto && mem_cnt >= mem_delay) || (kick_ack != kick_req)) begin
            i_MEM_RDY  = 1'b1;
            i_MEM_DATA = (int'(o_MEM_ADDR) < c_WORDS) ? mem_img[o_MEM_ADDR] : 16'hDEAD;
            mem_reads++;
            mem_cnt    = 0;
            kick_ack   = kick_req;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: what the HPS should read at byte address a
   function automatic logic [7:0] ref_byte(input logic [26:0] a);
      logic [15:0] w;
      if (int'(a) >= c_IMG) return 8'hFF;
      w = mem_img[int'(a) / 2];
      return (int'(a) % 2 == 1) ? w[7:0] : w[15:8];
   endfunction

   // One HPS byte read: strobe, then wait out ioctl_wait (bounded)
   task automatic rd_byte(input logic [26:0] a, output logic [7:0] d,
                          output int wait_cyc, output bit to);
      @(negedge clk);
      ioctl_rd   = 1'b1;
      ioctl_addr = a;
      @(negedge clk);
      ioctl_rd = 1'b0;
      wait_cyc = 0;
      to       = 1'b0;
      while (ioctl_wait && !to) begin
         wait_cyc++;
         if (wait_cyc > 300) to = 1'b1;
         else @(negedge clk);
      end
      d = ioctl_din;
   endtask

   typedef struct {
      logic [26:0] addr;
      logic [7:0]  din;
      bit          miss;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [7:0] d;
      logic [7:0] held;
      int         wc;
      int         r0;
      int         n;
      int         last_word;
      bit         to;

      for (int i = 0; i < c_WORDS; i++) mem_img[i] = 16'($urandom);
      mem_img[0]         = 16'hA55A;
      mem_img[1]         = 16'h1234;
      mem_img[20]        = 16'h7E81;
      mem_img[c_WORDS-1] = 16'hBEEF;

      vecs[0] = '{27'd163840,   8'hFF, 1'b0};
      vecs[1] = '{27'h4000000,  8'hFF, 1'b0};
      vecs[2] = '{27'd0,        8'hA5, 1'b0};
      vecs[3] = '{27'd163839,   8'hEF, 1'b1};
      vecs[4] = '{27'd163838,   8'hBE, 1'b0};
      vecs[5] = '{27'd3,        8'h34, 1'b1};
      vecs[6] = '{27'd2,        8'h12, 1'b0};
      vecs[7] = '{27'd1,        8'h5A, 1'b1};

      // Reset state, with a selecting session already presented
      ioctl_upload = 1'b1;
      ioctl_index  = 16'd4;
      repeat (2) @(negedge clk);
      chk("rst_din",  32'(ioctl_din), 32'h00);
      chk("rst_wait", 32'(ioctl_wait), 32'h0);
      chk("rst_rd",   32'(o_MEM_RD), 32'h0);
      chk("rst_addr", 32'(o_MEM_ADDR), 32'h0);
      chk("rst_lock", 32'(o_MEM_LOCK), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("lock_on", 32'(o_MEM_LOCK), 32'h1);

      // Miss with 6-cycle memory latency, then a hit on the other byte
      mem_delay = 6;
      r0 = mem_reads;
      rd_byte(27'd0, d, wc, to);
      chk("t1_timeout", 32'(to), 32'h0);
      chk("t1_din",   32'(d), 32'hA5);
      chk("t1_wait",  32'(wc), 32'd6);
      chk("t1_reads", 32'(mem_reads - r0), 32'd1);
      r0 = rd_cycles;
      rd_byte(27'd1, d, wc, to);
      chk("t1b_din",  32'(d), 32'h5A);
      chk("t1b_wait", 32'(wc), 32'd0);
      chk("t1b_rdcyc", 32'(rd_cycles - r0), 32'd0);

      // Vector table within the same session
      mem_delay = 2;
      foreach (vecs[i]) begin
         r0 = mem_reads;
         n  = rd_cycles;
         rd_byte(vecs[i].addr, d, wc, to);
         chk($sformatf("vec%0d_din", i),   32'(d), 32'(vecs[i].din));
         chk($sformatf("vec%0d_miss", i),  32'(wc != 0), 32'(vecs[i].miss));
         chk($sformatf("vec%0d_reads", i), 32'(mem_reads - r0), 32'(vecs[i].miss));
         if (!vecs[i].miss)
            chk($sformatf("vec%0d_rdcyc", i), 32'(rd_cycles - n), 32'd0);
      end

      // Wrong index: no response, lock drops, din holds
      held = ioctl_din;
      @(negedge clk);
      ioctl_index = 16'd0;
      @(negedge clk);
      chk("idx_lock", 32'(o_MEM_LOCK), 32'h0);
      r0 = mem_reads;
      rd_byte(27'd0, d, wc, to);
      chk("idx_din",   32'(d), 32'(held));
      chk("idx_wait",  32'(wc), 32'd0);
      chk("idx_reads", 32'(mem_reads - r0), 32'd0);
      ioctl_index = 16'd4;

      // Abort: session drops 2 cycles into a fetch, returns before the ack
      mem_auto = 1'b0;
      @(negedge clk);
      ioctl_rd   = 1'b1;
      ioctl_addr = 27'd40;
      @(negedge clk);
      ioctl_rd = 1'b0;
      chk("ab_wait_hi", 32'(ioctl_wait), 32'h1);
      @(negedge clk);
      ioctl_upload = 1'b0;
      @(negedge clk);
      chk("ab_wait_lo", 32'(ioctl_wait), 32'h0);
      chk("ab_rd_held", 32'(o_MEM_RD), 32'h1);
      chk("ab_lock",    32'(o_MEM_LOCK), 32'h0);
      repeat (3) @(negedge clk);
      chk("ab_rd_held2", 32'(o_MEM_RD), 32'h1);
      ioctl_upload = 1'b1;
      @(negedge clk);
      kick_req++;
      n = 0;
      while (o_MEM_RD && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ab_rd_drop", 32'(o_MEM_RD), 32'h0);
      chk("ab_wait_stay", 32'(ioctl_wait), 32'h0);
      mem_auto  = 1'b1;
      mem_delay = 3;
      r0 = mem_reads;
      rd_byte(27'd40, d, wc, to);
      chk("ab_new_din",   32'(d), 32'h7E);
      chk("ab_new_miss",  32'(wc), 32'd3);
      chk("ab_new_reads", 32'(mem_reads - r0), 32'd1);

      // Asynchronous reset while a fetch is outstanding
      mem_auto = 1'b0;
      @(negedge clk);
      ioctl_rd   = 1'b1;
      ioctl_addr = 27'd60;
      @(negedge clk);
      ioctl_rd = 1'b0;
      chk("mr_rd_hi", 32'(o_MEM_RD), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("mr_din",  32'(ioctl_din), 32'h00);
      chk("mr_wait", 32'(ioctl_wait), 32'h0);
      chk("mr_rd",   32'(o_MEM_RD), 32'h0);
      chk("mr_addr", 32'(o_MEM_ADDR), 32'h0);
      chk("mr_lock", 32'(o_MEM_LOCK), 32'h0);
      @(negedge clk);
      rst      = 1'b0;
      mem_auto = 1'b1;

      // Sequential upload of 16 bytes: first read misses, 8 fetches total
      r0 = mem_reads;
      for (int a = 0; a < 16; a++) begin
         mem_delay = $urandom_range(1, 5);
         rd_byte(27'(a), d, wc, to);
         chk($sformatf("seq%0d_din", a), 32'(d), 32'(ref_byte(27'(a))));
         if (a == 0) chk("seq_first_miss", 32'(wc != 0), 32'h1);
      end
      chk("seq_reads", 32'(mem_reads - r0), 32'd8);

      // Randomized reads against the image model
      @(negedge clk);
      ioctl_upload = 1'b0;
      @(negedge clk);
      ioctl_upload = 1'b1;
      last_word = -1;
      for (int i = 0; i < 150; i++) begin
         logic [26:0] a;
         logic [31:0] rv;
         bit          exp_miss;
         int          sel;
         if ($urandom_range(0, 19) == 0) begin
            @(negedge clk);
            ioctl_upload = 1'b0;
            @(negedge clk);
            ioctl_upload = 1'b1;
            last_word = -1;
         end
         sel = $urandom_range(0, 9);
         rv  = $urandom;
         if (sel < 7)       a = 27'($urandom_range(0, 31));
         else if (sel < 9)  a = 27'(c_IMG - 4 + $urandom_range(0, 7));
         else               a = rv[26:0];
         exp_miss = (int'(a) < c_IMG) && (int'(a) / 2 != last_word);
         if (exp_miss) last_word = int'(a) / 2;
         mem_delay = $urandom_range(1, 4);
         r0 = mem_reads;
         rd_byte(a, d, wc, to);
         chk("rnd_timeout", 32'(to), 32'h0);
         chk($sformatf("rnd%0d_din a=%0h", i, a), 32'(d), 32'(ref_byte(a)));
         chk($sformatf("rnd%0d_wait a=%0h", i, a), 32'(wc), exp_miss ? 32'(mem_delay) : 32'd0);
         chk($sformatf("rnd%0d_reads a=%0h", i, a), 32'(mem_reads - r0), 32'(exp_miss));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
